// File: rtl/add_sub_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
// Optional feature: define ADD_SUB_SEQ_OVF_EN to build the signed-overflow output.
package add_sub_seq_pkg;

  localparam int NIBBLE_W = 4;
  localparam int NUM_REQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/nibble_add_sub_slice.sv
// 4-bit combinational adder slice shared by the sequencer.
// Subtraction is handled by the parent: it inverts b and seeds cin with 1.
module nibble_add_sub_slice
  import add_sub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // Plain ripple add with one extra bit to capture the carry out
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/add_sub_sequencer.sv
// Arbitrates two requesters onto one 4-bit add/sub slice and walks the slice
// over NIBBLES cycles with a registered carry to build a W-bit result.
// Optional feature: define ADD_SUB_SEQ_OVF_EN to add the rsp_ovf output.
module add_sub_sequencer
  import add_sub_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_cout,
`ifdef ADD_SUB_SEQ_OVF_EN
  output logic                 rsp_ovf,
`endif
  output logic                 busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  req_id_t             lp;
  req_id_t             grant;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                sub_q;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  // Round-robin pick: on a tie the requester not granted last time wins
  always_comb begin
    grant = req_valid[1];
    if (&req_valid) begin
      grant = ~lp;
    end
  end

  // Only the granted requester sees ready, and only while idle
  always_comb begin
    req_ready = '0;
    if (state == IDLE && (|req_valid)) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Present the current nibble to the slice; b is inverted for subtract
  always_comb begin
    slice_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
    slice_b = b_q[idx*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
  end

  nibble_add_sub_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Main sequencer: accept, iterate the slice nibble by nibble, then hold the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lp       <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
`ifdef ADD_SUB_SEQ_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            a_q    <= grant ? req_a[2*W-1:W] : req_a[W-1:0];
            b_q    <= grant ? req_b[2*W-1:W] : req_b[W-1:0];
            sub_q  <= req_sub[grant];
            carry  <= req_sub[grant];
            idx    <= '0;
            rsp_id <= grant;
            lp     <= grant;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            rsp_cout <= slice_cout;
`ifdef ADD_SUB_SEQ_OVF_EN
            rsp_ovf  <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                        (slice_sum[NIBBLE_W-1] != a_q[W-1]);
`endif
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
